fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the MIPS-Lite 5-stage pipeline; producer side of the IF/ID interface that the decode stage consumes.
- Owns the PC, drives a synchronous-read instruction memory and holds the IF/ID pipeline register.
- Responds to decode-side feedback: hazardDetected stalls, branchTaken redirects and flushes, haltSignal freezes.

Parameters:
- ADDR_W, 32, PC/address width (matches ADDRESSWIDTH in mips_pkg).
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- hazardDetected  in  1  stall request from decode.
- branchTaken  in  1  redirect request from decode/execute.
- branchTarget  in  ADDR_W  redirect address; bits [1:0] ignored (forced 00).
- haltSignal  in  1  HALT decoded.
- imemEn  out  1  memory read enable; the memory holds its output when low.
- imemAddr  out  ADDR_W  read address; data returns next cycle.
- imemData  in  INSTR_W  read data for the previous cycle's enabled address.
- instruction  out  INSTR_W (Instruct)  IF/ID instruction.
- pcOut  out  ADDR_W  PC of the IF/ID instruction.
- validOut  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch frozen.

Behaviour:
- Registers:
  - pcReg: next address to present.
  - reqPc/reqValid: the in-flight request.
  - IF/ID: instruction, pcOut, validOut.
  - state: RUN or HALTED.
- Reset:
  - pcReg=RESET_PC; reqValid=0; reqPc=0.
  - instruction=NOP (32'h0); pcOut=0; validOut=0.
  - halted=0; state=RUN.
- Addressing: imemAddr=pcReg, always. imemEn=1 in RUN when not stalling; otherwise 0.
- Latency: the first valid IF/ID instruction appears 2 cycles after reset deasserts (cycle 1 requests, cycle 2 captures).
- Priority per cycle: reset > halt > branch > stall > advance.
- Advance (RUN, no other event):
  - IF/ID <= {reqValid ? imemData : NOP, reqPc, reqValid}.
  - reqPc <= pcReg; reqValid <= 1.
  - pcReg <= pcReg+4, modulo 2^ADDR_W (FFFF_FFFC wraps to 0, no flag).
- Stall (hazardDetected=1):
  - All registers hold; imemEn=0, so memory output stays valid for reqPc.
  - Consecutive stalls of any length are allowed.
- Branch (branchTaken=1, also during a stall):
  - IF/ID <= NOP with validOut=0; reqValid <= 0 (in-flight fetch squashed).
  - pcReg <= {branchTarget[ADDR_W-1:2],2'b00}.
  - The first target instruction is valid 2 cycles later.
  - Back-to-back branches: the latest target wins.
- Halt (haltSignal=1 in RUN):
  - Go to HALTED; IF/ID <= NOP with validOut=0; reqValid <= 0.
  - imemEn=0; pcReg holds; halted=1 from the next cycle.
  - HALTED ignores branch and stall; only reset leaves it.
- Simultaneous halt and branch: halt wins and pcReg holds.
- Reset mid-stall or mid-flush: reset values apply the next cycle; nothing partial survives.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - Adds outputs fetchCount, stallCount, flushCount, each 32 bits, zeroed by reset.
  - fetchCount increments on each advance that captures a valid instruction.
  - stallCount increments on each stall cycle in RUN.
  - flushCount increments on each branch.
  - All three saturate at FFFF_FFFF and freeze in HALTED.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- mips_pkg holds: Instruct typedef, ADDRESSWIDTH, NOP_INSTR=32'h0, fetch_state_e {RUN, HALTED}, PC_STEP=4.
- One sub-module, fetch_pc_unit: pcReg plus next-PC mux (increment / branch / hold) and priority resolution.
- fetch_stage keeps the request tracking, IF/ID register, state and the optional counters.

Test Plan:
- Reset, then 4 free-running cycles, memory returning addr-tagged data: validOut=1 at cycle 2 with pcOut=0, then pcOut 4, 8 in sequence; instruction equals memory word.
- hazardDetected held 3 cycles while pcOut=8: IF/ID, pcOut=8 and imemAddr hold; imemEn=0; the next advance gives pcOut=C with no skip or duplicate.
- branchTaken with branchTarget=32'h0000_0103 while pcOut=8: next cycle validOut=0 and instruction=NOP; pcOut=100 valid 2 cycles after the branch.
- haltSignal and branchTaken in the same cycle: halted=1 next cycle; imemEn=0, validOut=0 and imemAddr unchanged for 10 cycles; reset restores pcReg=0 and halted=0.
- pcReg=FFFF_FFF8 with no stall: the fetch sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- FETCH_STATS_EN: 5 advances, 2 stalls, 1 branch gives fetchCount=5-or-per-valid-capture, stallCount=2, flushCount=1; reset mid-stall zeroes all three and restores IF/ID to NOP.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-Lite types and constants for the fetch stage.
// Holds the instruction type, address width, NOP encoding, fetch FSM states,
// the PC increment and a saturating-increment helper for the statistics
// counters.
package mips_pkg;

    localparam int unsigned ADDRESSWIDTH = 32;
    localparam int unsigned INSTRWIDTH   = 32;
    localparam int unsigned STAT_W       = 32;
    localparam int unsigned PC_STEP      = 4;

    typedef logic [INSTRWIDTH-1:0] Instruct;

    localparam Instruct NOP_INSTR = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// PC register with next-PC selection and per-cycle event priority.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   run_i          fetch FSM is in RUN
//   halt_i         HALT decoded
//   branch_i       redirect request
//   hazard_i       stall request
//   target_i       redirect address (low two bits dropped)
//   pc_o           current PC (registered)
//   halt_c_o, branch_c_o, stall_c_o, adv_c_o
//                  resolved one-hot event for this cycle (combinational)
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDRESSWIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              halt_i,
    input  logic              branch_i,
    input  logic              hazard_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halt_c_o,
    output logic              branch_c_o,
    output logic              stall_c_o,
    output logic              adv_c_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              unused_target_lsbs;

    assign unused_target_lsbs = ^target_i[1:0];

    // Priority: halt > branch > stall > advance; nothing happens outside RUN.
    always_comb begin
        halt_c_o   = 1'b0;
        branch_c_o = 1'b0;
        stall_c_o  = 1'b0;
        adv_c_o    = 1'b0;
        pc_d       = pc_q;
        if (run_i) begin
            if (halt_i) begin
                halt_c_o = 1'b1;
            end else if (branch_i) begin
                branch_c_o = 1'b1;
                pc_d       = {target_i[ADDR_W-1:2], 2'b00};
            end else if (hazard_i) begin
                stall_c_o = 1'b1;
            end else begin
                adv_c_o = 1'b1;
                pc_d    = pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS-Lite IF stage: owns the PC, drives a synchronous-read instruction
// memory and holds the IF/ID pipeline register.
// Optional statistics counters are compiled in with FETCH_STATS_EN.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   hazardDetected  stall request from decode
//   branchTaken     redirect request; branchTarget is the new address
//   haltSignal      HALT decoded; freezes fetch until reset
//   imemEn/imemAddr memory read request (data returns next cycle on imemData)
//   instruction, pcOut, validOut   IF/ID register contents
//   halted          fetch frozen
//   fetchCount, stallCount, flushCount  (FETCH_STATS_EN only) event counters
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDRESSWIDTH,
    parameter int unsigned       INSTR_W  = INSTRWIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hazardDetected,
    input  logic               branchTaken,
    input  logic [ADDR_W-1:0]  branchTarget,
    input  logic               haltSignal,
    output logic               imemEn,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic [INSTR_W-1:0] imemData,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pcOut,
    output logic               validOut,
    output logic               halted
`ifdef FETCH_STATS_EN
    ,
    output logic [STAT_W-1:0]  fetchCount,
    output logic [STAT_W-1:0]  stallCount,
    output logic [STAT_W-1:0]  flushCount
`endif
);

    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               req_valid_q, req_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic               valid_q, valid_d;

    logic [ADDR_W-1:0]  pc;
    logic               halt_ev, branch_ev, stall_ev, adv_ev;

    fetch_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .run_i      (state_q == RUN),
        .halt_i     (haltSignal),
        .branch_i   (branchTaken),
        .hazard_i   (hazardDetected),
        .target_i   (branchTarget),
        .pc_o       (pc),
        .halt_c_o   (halt_ev),
        .branch_c_o (branch_ev),
        .stall_c_o  (stall_ev),
        .adv_c_o    (adv_ev)
    );

    // Read only while fetch is live; holding imemEn low keeps the memory
    // output valid for req_pc_q across a stall.
    assign imemEn   = adv_ev | branch_ev;
    assign imemAddr = pc;

    // Request tracking, IF/ID register and FSM next state.
    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        if (halt_ev) begin
            state_d     = HALTED;
            instr_d     = NOP_W;
            valid_d     = 1'b0;
            req_valid_d = 1'b0;
        end else if (branch_ev) begin
            // Squash both the IF/ID entry and the fetch already in flight.
            instr_d     = NOP_W;
            valid_d     = 1'b0;
            req_valid_d = 1'b0;
        end else if (adv_ev) begin
            instr_d     = req_valid_q ? imemData : NOP_W;
            pc_out_d    = req_pc_q;
            valid_d     = req_valid_q;
            req_pc_d    = pc;
            req_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            instr_q     <= NOP_W;
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
        end
    end

    assign instruction = instr_q;
    assign pcOut       = pc_out_q;
    assign validOut    = valid_q;
    assign halted      = (state_q == HALTED);

`ifdef FETCH_STATS_EN
    logic [STAT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Events only fire in RUN, so the counters freeze once HALTED.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (adv_ev && req_valid_q) fetch_cnt_d = sat_inc(fetch_cnt_q);
        if (stall_ev)              stall_cnt_d = sat_inc(stall_cnt_q);
        if (branch_ev)             flush_cnt_d = sat_inc(flush_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed phases push the expected IF/ID
// entries (pc, word) as stimulus is issued; a negedge monitor pops one entry
// each time decode would consume a valid IF/ID entry (validOut && !stall).
// The memory model returns addr ^ 32'hC0DE_0000 one cycle after an enabled read.
module tb_fetch_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hazardDetected = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = 32'h0;
    logic        haltSignal = 1'b0;
    logic        imemEn;
    logic [31:0] imemAddr;
    logic [31:0] imemData = 32'h0;
    logic [31:0] instruction;
    logic [31:0] pcOut;
    logic        validOut;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] fetchCount, stallCount, flushCount;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .hazardDetected (hazardDetected),
        .branchTaken    (branchTaken),
        .branchTarget   (branchTarget),
        .haltSignal     (haltSignal),
        .imemEn         (imemEn),
        .imemAddr       (imemAddr),
        .imemData       (imemData),
        .instruction    (instruction),
        .pcOut          (pcOut),
        .validOut       (validOut),
        .halted         (halted)
`ifdef FETCH_STATS_EN
        ,
        .fetchCount     (fetchCount),
        .stallCount     (stallCount),
        .flushCount     (flushCount)
`endif
    );

    // Synchronous-read instruction memory; holds its output when not enabled.
    always @(posedge clk) begin
        if (imemEn) imemData <= imemAddr ^ 32'hC0DE_0000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        hazardDetected = 1'b0;
        branchTaken    = 1'b0;
        haltSignal     = 1'b0;
        branchTarget   = 32'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Monitor: decode consumes the IF/ID entry whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (!reset && validOut && !hazardDetected) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_capture: pcOut=%08h instr=%08h with empty queue", pcOut, instruction);
            end else begin
                me = q.pop_front();
                chk("scb_pc", pcOut, me.pc);
                chk("scb_instr", instruction, me.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Phase A: reset values, free run, 3-cycle stall at pcOut=8.
        do_reset();
        chk("rst_valid", 32'(validOut), 32'h0);
        chk("rst_pcout", pcOut, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_addr", imemAddr, 32'h0);
        push(32'h0, 32'hC0DE_0000);
        push(32'h4, 32'hC0DE_0004);
        push(32'h8, 32'hC0DE_0008);
        step();
        chk("lat_c1_valid", 32'(validOut), 32'h0);
        step();
        chk("lat_c2_valid", 32'(validOut), 32'h1);
        chk("lat_c2_pc", pcOut, 32'h0);
        step();
        step();
        hazardDetected = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pcOut, 32'h8);
            chk("stall_valid", 32'(validOut), 32'h1);
            chk("stall_addr", imemAddr, 32'h10);
            chk("stall_en", 32'(imemEn), 32'h0);
        end
        hazardDetected = 1'b0;
        push(32'hC, 32'hC0DE_000C);
        step();
        chk("post_stall_pc", pcOut, 32'hC);
        step();

        // Phase B: branch to 0x103 while pcOut=8.
        do_reset();
        push(32'h0, 32'hC0DE_0000);
        push(32'h4, 32'hC0DE_0004);
        push(32'h8, 32'hC0DE_0008);
        step();
        step();
        step();
        step();
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0103;
        push(32'h100, 32'hC0DE_0100);
        step();
        branchTaken = 1'b0;
        chk("br_valid", 32'(validOut), 32'h0);
        chk("br_instr", instruction, 32'h0);
        chk("br_addr", imemAddr, 32'h100);
        step();
        chk("br_c1_valid", 32'(validOut), 32'h0);
        step();
        chk("br_c2_valid", 32'(validOut), 32'h1);
        chk("br_c2_pc", pcOut, 32'h100);
        step();

        // Phase C: halt and branch together; HALTED ignores branch/stall.
        do_reset();
        push(32'h0, 32'hC0DE_0000);
        push(32'h4, 32'hC0DE_0004);
        step();
        step();
        step();
        haltSignal   = 1'b1;
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0200;
        step();
        haltSignal   = 1'b0;
        branchTarget = 32'h0000_0300;
        for (int i = 0; i < 10; i++) begin
            chk("halt_halted", 32'(halted), 32'h1);
            chk("halt_valid", 32'(validOut), 32'h0);
            chk("halt_en", 32'(imemEn), 32'h0);
            chk("halt_addr", imemAddr, 32'hC);
            branchTaken    = i[0];
            hazardDetected = i[1];
            step();
        end
        do_reset();
        chk("unhalt_halted", 32'(halted), 32'h0);
        chk("unhalt_addr", imemAddr, 32'h0);

        // Phase D: PC wrap from FFFF_FFF8.
        branchTaken  = 1'b1;
        branchTarget = 32'hFFFF_FFF8;
        push(32'hFFFF_FFF8, 32'h3F21_FFF8);
        push(32'hFFFF_FFFC, 32'h3F21_FFFC);
        push(32'h0000_0000, 32'hC0DE_0000);
        step();
        branchTaken = 1'b0;
        chk("wrap_addr0", imemAddr, 32'hFFFF_FFF8);
        chk("wrap_valid0", 32'(validOut), 32'h0);
        step();
        chk("wrap_addr1", imemAddr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr2", imemAddr, 32'h0);
        chk("wrap_pc0", pcOut, 32'hFFFF_FFF8);
        step();
        step();
        step();

        // Phase E: counters, then reset in the middle of a stall.
        do_reset();
        push(32'h0, 32'hC0DE_0000);
        push(32'h4, 32'hC0DE_0004);
        push(32'h8, 32'hC0DE_0008);
        push(32'hC, 32'hC0DE_000C);
        push(32'h10, 32'hC0DE_0010);
        for (int i = 0; i < 6; i++) step();
        hazardDetected = 1'b1;
        step();
        step();
        hazardDetected = 1'b0;
        branchTaken    = 1'b1;
        branchTarget   = 32'h0000_0043;
        step();
        branchTaken = 1'b0;
        chk("e_br_valid", 32'(validOut), 32'h0);
        chk("e_br_addr", imemAddr, 32'h40);
`ifdef FETCH_STATS_EN
        chk("stat_fetch", fetchCount, 32'd5);
        chk("stat_stall", stallCount, 32'd2);
        chk("stat_flush", flushCount, 32'd1);
`endif
        step();
        step();
        chk("e_tgt_valid", 32'(validOut), 32'h1);
        chk("e_tgt_pc", pcOut, 32'h40);
        chk("e_tgt_instr", instruction, 32'hC0DE_0040);
        hazardDetected = 1'b1;
        step();
        chk("e_stall_pc", pcOut, 32'h40);
        chk("e_stall_en", 32'(imemEn), 32'h0);
`ifdef FETCH_STATS_EN
        chk("stat_fetch2", fetchCount, 32'd6);
        chk("stat_stall2", stallCount, 32'd3);
`endif
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(validOut), 32'h0);
        chk("mid_rst_instr", instruction, 32'h0);
        chk("mid_rst_pc", pcOut, 32'h0);
        chk("mid_rst_addr", imemAddr, 32'h0);
        chk("mid_rst_halted", 32'(halted), 32'h0);
`ifdef FETCH_STATS_EN
        chk("stat_rst_fetch", fetchCount, 32'd0);
        chk("stat_rst_stall", stallCount, 32'd0);
        chk("stat_rst_flush", flushCount, 32'd0);
`endif
        hazardDetected = 1'b0;
        step();
        step();
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
